// File: rtl/axi_pwm_custom_gen.sv
// Four-channel PWM generator. Duties are latched at period wrap and can be
// slew-limited per period, so the LED outputs never glitch mid-period.
module axi_pwm_custom_gen #(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4,
    parameter int RAMP_STEP  = 0
) (
    input  logic                  pwm_clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_channel_0,
    input  logic [DATA_WIDTH-1:0] data_channel_1,
    input  logic [DATA_WIDTH-1:0] data_channel_2,
    input  logic [DATA_WIDTH-1:0] data_channel_3,
    output logic                  pwm_led_0,
    output logic                  pwm_led_1,
    output logic                  pwm_led_2,
    output logic                  pwm_led_3,
    output logic                  period_start
);
    localparam int W = DATA_WIDTH;
    localparam logic [15:0]  DIV_LAST = 16'(CLK_DIV - 1);
    // The counter stops one short of all-ones so that duty 2^W-1 is constant high.
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W:0]   STEP     = (W+1)'(RAMP_STEP);

    logic [15:0]  div_cnt_reg;
    logic [W-1:0] cnt_reg;
    logic         tick;
    logic         wrap;
    logic [W-1:0] data_arr [4];
    logic [3:0]   led_bits;

    assign tick = (div_cnt_reg == DIV_LAST);
    assign wrap = tick && (cnt_reg == CNT_LAST);

    assign data_arr[0] = data_channel_0;
    assign data_arr[1] = data_channel_1;
    assign data_arr[2] = data_channel_2;
    assign data_arr[3] = data_channel_3;

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_reg  <= '0;
            cnt_reg      <= '0;
            period_start <= 1'b0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 16'd1;
            if (wrap) begin
                cnt_reg <= '0;
            end else if (tick) begin
                cnt_reg <= cnt_reg + W'(1);
            end
            period_start <= wrap;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic [W-1:0] tgt_reg;
            logic [W-1:0] tgt_next;
            logic [W-1:0] cur_reg;
            logic [W-1:0] cur_next;
            logic [W:0]   d_ext;
            logic [W:0]   c_ext;
            logic [W:0]   diff;
            logic         led_reg;

            // The slew is computed from the value being latched this cycle,
            // so a target change in the wrap cycle itself takes effect.
            always_comb begin
                tgt_next = wrap ? data_arr[gi] : tgt_reg;
                d_ext    = {1'b0, tgt_next};
                c_ext    = {1'b0, cur_reg};
                diff     = (d_ext >= c_ext) ? (d_ext - c_ext) : (c_ext - d_ext);
                cur_next = tgt_next;
                if ((STEP != '0) && (diff > STEP)) begin
                    if (d_ext > c_ext) begin
                        cur_next = W'(c_ext + STEP);
                    end else begin
                        cur_next = W'(c_ext - STEP);
                    end
                end
            end

            always_ff @(posedge pwm_clk or negedge rstn) begin
                if (!rstn) begin
                    tgt_reg <= '0;
                    cur_reg <= '0;
                    led_reg <= 1'b0;
                end else begin
                    tgt_reg <= tgt_next;
                    if (wrap) begin
                        cur_reg <= cur_next;
                    end
                    led_reg <= (cnt_reg < cur_reg);
                end
            end

            assign led_bits[gi] = led_reg;
        end
    endgenerate

    assign pwm_led_0 = led_bits[0];
    assign pwm_led_1 = led_bits[1];
    assign pwm_led_2 = led_bits[2];
    assign pwm_led_3 = led_bits[3];
endmodule

// File: tb/tb_axi_pwm_custom_gen.sv
// Bench for axi_pwm_custom_gen: per-period high-time scoreboard on a direct and a
// slewed instance, fixed checks on a prescaled instance, and a mid-period reset.
module tb_axi_pwm_custom_gen;
    logic clk;
    logic rstn;
    logic [11:0] d0, d1, d2, d3;
    logic [11:0] p0, p1, p2, p3;
    logic [3:0] led_a, led_r, led_p;
    logic ps_a, ps_r, ps_p;
    logic mon_en;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    axi_pwm_custom_gen #(.DATA_WIDTH(12), .CLK_DIV(1), .RAMP_STEP(0)) dut_a (
        .pwm_clk(clk), .rstn(rstn),
        .data_channel_0(d0), .data_channel_1(d1), .data_channel_2(d2), .data_channel_3(d3),
        .pwm_led_0(led_a[0]), .pwm_led_1(led_a[1]), .pwm_led_2(led_a[2]), .pwm_led_3(led_a[3]),
        .period_start(ps_a)
    );

    axi_pwm_custom_gen #(.DATA_WIDTH(12), .CLK_DIV(1), .RAMP_STEP(256)) dut_r (
        .pwm_clk(clk), .rstn(rstn),
        .data_channel_0(d0), .data_channel_1(d1), .data_channel_2(d2), .data_channel_3(d3),
        .pwm_led_0(led_r[0]), .pwm_led_1(led_r[1]), .pwm_led_2(led_r[2]), .pwm_led_3(led_r[3]),
        .period_start(ps_r)
    );

    axi_pwm_custom_gen #(.DATA_WIDTH(12), .CLK_DIV(4), .RAMP_STEP(0)) dut_p (
        .pwm_clk(clk), .rstn(rstn),
        .data_channel_0(p0), .data_channel_1(p1), .data_channel_2(p2), .data_channel_3(p3),
        .pwm_led_0(led_p[0]), .pwm_led_1(led_p[1]), .pwm_led_2(led_p[2]), .pwm_led_3(led_p[3]),
        .period_start(ps_p)
    );

    typedef struct {
        int d0; int d1; int d2; int d3;
        int late;     // drive in the wrap cycle instead of early in the period
        int exp_r0;   // slewed channel-0 high time expected in the following period
    } vec_t;

    typedef struct packed {
        logic [15:0]       win;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  r;
    } exp_t;

    vec_t vecs [13];
    exp_t sb [$];
    int   cur_r [4];
    int   win_cnt = 0;
    int   p_win = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int ramp(input int cur, input int tgt, input int step);
        if (tgt >= cur) return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (ps_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL period_start_timeout got 0 want 1");
            finish_now();
        end
    endtask

    task automatic drive(input int i);
        exp_t e;
        int dv [4];
        d0 = 12'(vecs[i].d0); d1 = 12'(vecs[i].d1);
        d2 = 12'(vecs[i].d2); d3 = 12'(vecs[i].d3);
        dv[0] = vecs[i].d0; dv[1] = vecs[i].d1; dv[2] = vecs[i].d2; dv[3] = vecs[i].d3;
        e.win = 16'(i + 1);
        for (int ch = 0; ch < 4; ch++) begin
            cur_r[ch] = ramp(cur_r[ch], dv[ch], 256);
            e.a[ch] = 16'(dv[ch]);
            e.r[ch] = 16'(cur_r[ch]);
        end
        e.r[0] = 16'(vecs[i].exp_r0);
        sb.push_back(e);
        $display("drive vec %0d: %0d %0d %0d %0d late=%0d", i, dv[0], dv[1], dv[2], dv[3], vecs[i].late);
    endtask

    // Scoreboard monitor: a window runs from the cycle after one period_start
    // through the next period_start inclusive.
    initial begin
        int acc_a [4];
        int acc_r [4];
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin acc_a[ch] = 0; acc_r[ch] = 0; end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int ch = 0; ch < 4; ch++) begin
                    acc_a[ch] += int'(led_a[ch]);
                    acc_r[ch] += int'(led_r[ch]);
                end
                if (ps_a) begin
                    if (sb.size() > 0 && int'(sb[0].win) == win_cnt) begin
                        e = sb.pop_front();
                        for (int ch = 0; ch < 4; ch++) begin
                            check($sformatf("hi_a win%0d ch%0d", win_cnt, ch), acc_a[ch], int'(e.a[ch]));
                            check($sformatf("hi_r win%0d ch%0d", win_cnt, ch), acc_r[ch], int'(e.r[ch]));
                        end
                        $display("window %0d: a=%0d,%0d,%0d,%0d r=%0d,%0d,%0d,%0d", win_cnt,
                                 acc_a[0], acc_a[1], acc_a[2], acc_a[3], acc_r[0], acc_r[1], acc_r[2], acc_r[3]);
                    end
                    for (int ch = 0; ch < 4; ch++) begin acc_a[ch] = 0; acc_r[ch] = 0; end
                    win_cnt++;
                end
            end
        end
    end

    // Prescaled instance: fixed duties 10, 0, 4095, 1000 with CLK_DIV=4.
    initial begin
        int acc_p [4];
        int p_cyc;
        p_cyc = 0;
        for (int ch = 0; ch < 4; ch++) acc_p[ch] = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                p_cyc++;
                for (int ch = 0; ch < 4; ch++) acc_p[ch] += int'(led_p[ch]);
                if (ps_p) begin
                    if (p_win >= 1) begin
                        check($sformatf("p_spacing win%0d", p_win), p_cyc, 16380);
                        check($sformatf("p_hi win%0d ch0", p_win), acc_p[0], 40);
                        check($sformatf("p_hi win%0d ch1", p_win), acc_p[1], 0);
                        check($sformatf("p_hi win%0d ch2", p_win), acc_p[2], 16380);
                        check($sformatf("p_hi win%0d ch3", p_win), acc_p[3], 4000);
                        $display("prescaled window %0d: spacing=%0d hi=%0d,%0d,%0d,%0d", p_win,
                                 p_cyc, acc_p[0], acc_p[1], acc_p[2], acc_p[3]);
                    end
                    p_cyc = 0;
                    for (int ch = 0; ch < 4; ch++) acc_p[ch] = 0;
                    p_win++;
                end
            end
        end
    end

    initial begin
        int n;
        int hi;
        exp_t z;
        vecs[0]  = '{1024, 0,    4095, 100,  0, 256};
        vecs[1]  = '{1024, 0,    4095, 3000, 0, 512};
        vecs[2]  = '{1024, 0,    4095, 3000, 0, 768};
        vecs[3]  = '{0,    7,    2048, 1,    1, 512};
        vecs[4]  = '{0,    4094, 2048, 0,    0, 256};
        vecs[5]  = '{0,    4094, 0,    4095, 0, 0};
        vecs[6]  = '{0,    4094, 0,    4095, 1, 0};
        vecs[7]  = '{1000, 5,    0,    4095, 0, 256};
        vecs[8]  = '{1000, 5,    300,  2000, 0, 512};
        vecs[9]  = '{1000, 5,    300,  2000, 0, 768};
        vecs[10] = '{1000, 2222, 300,  2000, 0, 1000};
        vecs[11] = '{1000, 2222, 4000, 2000, 0, 1000};
        vecs[12] = '{3000, 3000, 3000, 3000, 0, 1256};
        for (int ch = 0; ch < 4; ch++) cur_r[ch] = 0;

        rstn = 1'b0; mon_en = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        p0 = 12'd10; p1 = 12'd0; p2 = 12'd4095; p3 = 12'd1000;
        repeat (3) @(negedge clk);
        check("reset_leds", int'({led_a, led_r, led_p}), 0);
        check("reset_period_start", int'({ps_a, ps_r, ps_p}), 0);
        $display("reset: leds=%h%h%h ps=%b%b%b", led_a, led_r, led_p, ps_a, ps_r, ps_p);

        rstn = 1'b1;
        mon_en = 1'b1;
        z = '0;
        sb.push_back(z);          // outputs stay low until the first wrap
        drive(0);
        for (int i = 1; i < 13; i++) begin
            wait_ps();
            repeat (vecs[i].late != 0 ? 4094 : 50) @(negedge clk);
            drive(i);
        end
        wait_ps();
        wait_ps();
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        for (int k = 0; k < 40000 && p_win < 3; k++) @(negedge clk);
        check("prescaled_windows_seen", int'(p_win >= 3), 1);
        mon_en = 1'b0;

        // Reset in the middle of a period with all duties at 3000.
        wait_ps();
        repeat (2000) @(negedge clk);
        check("pre_reset_leds_high", int'(led_a), 15);
        rstn = 1'b0;
        #1;
        check("reset_async_drop", int'({led_a, led_r, led_p, ps_a, ps_r, ps_p}), 0);
        $display("mid-period reset: leds=%h%h%h", led_a, led_r, led_p);
        repeat (5) @(negedge clk);
        check("reset_hold", int'({led_a, led_r, led_p, ps_a, ps_r, ps_p}), 0);
        rstn = 1'b1;
        n = 0;
        hi = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            n++;
            hi += int'(led_a != 4'h0) + int'(led_r != 4'h0);
            if (ps_a) break;
        end
        check("post_reset_low", hi, 0);
        check("first_wrap_after_reset", n, 4095);
        @(negedge clk);
        check("post_wrap_leds_high", int'(led_a), 15);
        $display("after release: first wrap at %0d clocks, leds=%h", n, led_a);
        finish_now();
    end
endmodule
